ins_loader: RTL and testbench

- Byte-stream program loader; the writer side of instruction memory, which the instruction decoder reads.
- Receives a framed program over a ready/valid byte stream (from the host link, e.g. a UART bridge).
- Assembles each instruction word {a_addr, b_addr, r_addr, opcode}, writes it to instruction memory and appends a NOP terminator when the program is shorter than memory.
- Pulses ins_valid so the decoder's PC leaves its parked all-ones state.

---
 rtl/ins_loader_pkg.sv | 36 +++
 rtl/ins_byte_assembler.sv | 53 +++++
 rtl/ins_loader.sv | 208 ++++++++++++++++++++
 tb/tb_ins_loader.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ins_loader_pkg.sv
// Shared constants and types for the instruction loader: instruction word
// geometry, the opcode encoding seen by the decoder, and the loader FSM states.
// Word layout (MSB..LSB): {a_addr, b_addr, r_addr, opcode}.
package ins_loader_pkg;

  localparam int OPCODE_WIDTH   = 3;
  localparam int DEF_ADDR_WIDTH = 10;
  localparam int INS_WIDTH      = OPCODE_WIDTH + 3 * DEF_ADDR_WIDTH;
  localparam int BYTES_PER_INS  = (INS_WIDTH + 7) / 8;

  typedef enum logic [OPCODE_WIDTH-1:0] {
    OP_NOP       = 3'b000,
    OP_ADD       = 3'b001,
    OP_SUB       = 3'b010,
    OP_MUL       = 3'b011,
    OP_DOT_SHIFT = 3'b100,
    OP_DOT_ACC   = 3'b101,
    OP_DOT_CLR   = 3'b110,
    OP_PASS_B    = 3'b111
  } opcode_e;

  typedef enum logic [2:0] {
    ST_HDR_LO,
    ST_HDR_HI,
    ST_LOAD,
    ST_TERM,
    ST_CHK,
    ST_DONE
  } ld_state_e;

  // Stream bytes needed to carry a word of the given width.
  function automatic int bytes_for(input int width);
    return (width + 7) / 8;
  endfunction

endpackage

// File: rtl/ins_byte_assembler.sv
// Collects BPI little-endian stream bytes into one instruction word.
// Ports: clr restarts the byte counter; byte_vld/byte_dat present an accepted
// byte; word/word_done are combinational and valid while the last byte is on byte_dat.
module ins_byte_assembler #(
  parameter int INS_W = 33,
  parameter int BPI   = 5
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             clr,
  input  logic             byte_vld,
  input  logic [7:0]       byte_dat,
  output logic [INS_W-1:0] word,
  output logic             word_done
);

  localparam int            CW   = (BPI > 1) ? $clog2(BPI) : 1;
  localparam int            SW   = 8 * (BPI - 1);
  localparam logic [CW-1:0] LAST = CW'(BPI - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic [SW-1:0] sh_q, sh_d;

  always_comb begin
    cnt_d     = cnt_q;
    sh_d      = sh_q;
    word_done = byte_vld && (cnt_q == LAST);
    // Earlier bytes have shifted down so byte 0 sits at [7:0]; the final byte
    // goes straight to the top, bits beyond INS_W are dropped.
    word      = INS_W'({byte_dat, sh_q});
    if (clr) begin
      cnt_d = '0;
    end else if (byte_vld) begin
      if (cnt_q == LAST) begin
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
        sh_d  = {byte_dat, sh_q[SW-1:8]};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      cnt_q <= '0;
      sh_q  <= '0;
    end else begin
      cnt_q <= cnt_d;
      sh_q  <= sh_d;
    end
  end

endmodule

// File: rtl/ins_loader.sv
// Program loader: parses a framed byte stream (16-bit LE count, then words) and
// writes instruction memory, adding a NOP terminator when the program is short.
// Ports: s_* byte stream in; ins_wr_* memory write port; ins_valid completion
// pulse; load_busy/load_err/ins_count status. Optional checksum byte: INS_LOADER_CHECKSUM_EN.
module ins_loader
  import ins_loader_pkg::*;
#(
  parameter  int INS_ADDR_WIDTH = 10,
  parameter  int ADDR_WIDTH     = DEF_ADDR_WIDTH,
  localparam int INS_W          = OPCODE_WIDTH + 3 * ADDR_WIDTH,
  localparam int BPI            = bytes_for(INS_W)
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic [7:0]                s_data,
  input  logic                      s_valid,
  output logic                      s_ready,
  output logic                      ins_wr_en,
  output logic [INS_ADDR_WIDTH-1:0] ins_wr_addr,
  output logic [INS_W-1:0]          ins_wr_data,
  output logic                      ins_valid,
  output logic                      load_busy,
  output logic                      load_err,
  output logic [INS_ADDR_WIDTH:0]   ins_count
);

  localparam logic [16:0] DEPTH = 17'(1 << INS_ADDR_WIDTH);

`ifdef INS_LOADER_CHECKSUM_EN
  localparam ld_state_e POST_ST = ST_CHK;
`else
  localparam ld_state_e POST_ST = ST_DONE;
`endif

  ld_state_e                 state_q, state_d;
  logic [15:0]               n_q, n_d;
  logic [16:0]               idx_q, idx_d;
  logic                      s_ready_q, s_ready_d;
  logic                      wr_en_q, wr_en_d;
  logic [INS_ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
  logic [INS_W-1:0]          wr_data_q, wr_data_d;
  logic                      valid_q, valid_d;
  logic                      busy_q, busy_d;
  logic                      err_q, err_d;
  logic [INS_ADDR_WIDTH:0]   count_q, count_d;

  logic                      acc;
  logic [INS_W-1:0]          asm_word;
  logic                      asm_done;
  logic [16:0]               n_ext;
  logic [16:0]               hdr_n;

  assign acc   = s_valid && s_ready_q;
  assign n_ext = {1'b0, n_q};
  assign hdr_n = {1'b0, s_data, n_q[7:0]};

  ins_byte_assembler #(
    .INS_W (INS_W),
    .BPI   (BPI)
  ) u_asm (
    .clk       (clk),
    .rstn      (rstn),
    .clr       (acc && (state_q == ST_HDR_HI)),
    .byte_vld  (acc && (state_q == ST_LOAD)),
    .byte_dat  (s_data),
    .word      (asm_word),
    .word_done (asm_done)
  );

`ifdef INS_LOADER_CHECKSUM_EN
  logic [7:0] csum_q, csum_d;

  // Running XOR restarts on the first header byte of every frame.
  always_comb begin
    csum_d = csum_q;
    if (acc) begin
      csum_d = (state_q == ST_HDR_LO) ? s_data : (csum_q ^ s_data);
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) csum_q <= '0;
    else       csum_q <= csum_d;
  end
`endif

  always_comb begin
    state_d   = state_q;
    n_d       = n_q;
    idx_d     = idx_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    valid_d   = 1'b0;
    busy_d    = busy_q;
    err_d     = err_q;
    count_d   = count_q;

    case (state_q)
      ST_HDR_LO: begin
        if (acc) begin
          n_d[7:0] = s_data;
          state_d  = ST_HDR_HI;
        end
      end
      ST_HDR_HI: begin
        if (acc) begin
          n_d[15:8] = s_data;
          err_d     = 1'b0;
          busy_d    = 1'b1;
          idx_d     = '0;
          if (hdr_n > DEPTH) begin
            // Program cannot fit: reject the whole frame before any write.
            err_d   = 1'b1;
            busy_d  = 1'b0;
            state_d = ST_HDR_LO;
          end else if (hdr_n == 17'd0) begin
            state_d = ST_TERM;
          end else begin
            state_d = ST_LOAD;
          end
        end
      end
      ST_LOAD: begin
        if (asm_done) begin
          wr_en_d   = 1'b1;
          wr_addr_d = idx_q[INS_ADDR_WIDTH-1:0];
          wr_data_d = asm_word;
          idx_d     = idx_q + 17'd1;
          if ((idx_q + 17'd1) == n_ext) begin
            // A full memory needs no terminator; the decoder stops at PC all-ones.
            state_d = (n_ext < DEPTH) ? ST_TERM : POST_ST;
          end
        end
      end
      ST_TERM: begin
        wr_en_d   = 1'b1;
        wr_addr_d = n_q[INS_ADDR_WIDTH-1:0];
        wr_data_d = '0;
        state_d   = POST_ST;
      end
`ifdef INS_LOADER_CHECKSUM_EN
      ST_CHK: begin
        if (acc) begin
          if ((csum_q ^ s_data) == 8'h00) begin
            state_d = ST_DONE;
          end else begin
            err_d   = 1'b1;
            busy_d  = 1'b0;
            state_d = ST_HDR_LO;
          end
        end
      end
`endif
      ST_DONE: begin
        valid_d = 1'b1;
        count_d = n_q[INS_ADDR_WIDTH:0];
        busy_d  = 1'b0;
        state_d = ST_HDR_LO;
      end
      default: begin
        state_d = ST_HDR_LO;
      end
    endcase

    // Ready is registered from the next state so it tracks state_q exactly.
    s_ready_d = (state_d == ST_HDR_LO) || (state_d == ST_HDR_HI) ||
                (state_d == ST_LOAD)   || (state_d == ST_CHK);
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q   <= ST_HDR_LO;
      n_q       <= '0;
      idx_q     <= '0;
      s_ready_q <= 1'b0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
      err_q     <= 1'b0;
      count_q   <= '0;
    end else begin
      state_q   <= state_d;
      n_q       <= n_d;
      idx_q     <= idx_d;
      s_ready_q <= s_ready_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      valid_q   <= valid_d;
      busy_q    <= busy_d;
      err_q     <= err_d;
      count_q   <= count_d;
    end
  end

  assign s_ready     = s_ready_q;
  assign ins_wr_en   = wr_en_q;
  assign ins_wr_addr = wr_addr_q;
  assign ins_wr_data = wr_data_q;
  assign ins_valid   = valid_q;
  assign load_busy   = busy_q;
  assign load_err    = err_q;
  assign ins_count   = count_q;

endmodule

// File: tb/tb_ins_loader.sv
// Directed bench for ins_loader: a cycle-exact vector table for the single-ADD
// frame plus frame-level sequences for N=0, stalls, oversize, full memory, reset
// abort and (with INS_LOADER_CHECKSUM_EN) a bad checksum.
module tb_ins_loader;
  import ins_loader_pkg::*;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic [7:0]  s_data = 8'h00;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic        ins_wr_en;
  logic [9:0]  ins_wr_addr;
  logic [32:0] ins_wr_data;
  logic        ins_valid;
  logic        load_busy;
  logic        load_err;
  logic [10:0] ins_count;

  always #5 clk = ~clk;

  ins_loader dut (
    .clk         (clk),
    .rstn        (rstn),
    .s_data      (s_data),
    .s_valid     (s_valid),
    .s_ready     (s_ready),
    .ins_wr_en   (ins_wr_en),
    .ins_wr_addr (ins_wr_addr),
    .ins_wr_data (ins_wr_data),
    .ins_valid   (ins_valid),
    .load_busy   (load_busy),
    .load_err    (load_err),
    .ins_count   (ins_count)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Write/pulse monitor, sampled on the falling edge.
  logic [9:0]  wa_q[$];
  logic [32:0] wd_q[$];
  int          vcnt = 0;
  int          overlap = 0;

  always @(negedge clk) begin
    if (ins_wr_en === 1'b1) begin
      wa_q.push_back(ins_wr_addr);
      wd_q.push_back(ins_wr_data);
    end
    if (ins_valid === 1'b1) vcnt++;
    if (ins_valid === 1'b1 && ins_wr_en === 1'b1) overlap++;
  end

  task automatic clear_mon();
    wa_q.delete();
    wd_q.delete();
    vcnt = 0;
  endtask

  function automatic logic [63:0] outs();
    return {5'b0, s_ready, ins_wr_en, ins_wr_addr, ins_wr_data,
            ins_valid, load_busy, load_err, ins_count};
  endfunction

  function automatic logic [32:0] mk(input logic [2:0] op, input logic [9:0] a,
                                     input logic [9:0] b, input logic [9:0] r);
    return {a, b, r, op};
  endfunction

  logic [32:0] prog [0:1023];

  // Called at a falling edge; returns at the falling edge after the accept.
  task automatic send_byte(input logic [7:0] b, input int gap);
    int t = 0;
    s_valid = 1'b1;
    s_data  = b;
    while (s_ready !== 1'b1 && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (s_ready !== 1'b1) begin
      n_checks++;
      n_fail++;
      $display("FAIL ready_timeout: s_ready=%b required 1 for byte 0x%0h", s_ready, b);
    end
    @(negedge clk);
    s_valid = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic send_frame(input int n, input int gap, input bit corrupt);
    logic [15:0] nn;
    logic [39:0] wb;
    logic [7:0]  x;
    nn = 16'(n);
    x  = nn[7:0] ^ nn[15:8];
    send_byte(nn[7:0], gap);
    send_byte(nn[15:8], gap);
    if (n <= 1024) begin
      for (int i = 0; i < n; i++) begin
        wb = 40'(prog[i]);
        for (int k = 0; k < 5; k++) begin
          x = x ^ wb[8*k +: 8];
          send_byte(wb[8*k +: 8], gap);
        end
      end
`ifdef INS_LOADER_CHECKSUM_EN
      send_byte(corrupt ? (x ^ 8'h5A) : x, gap);
`endif
    end
    repeat (6) @(negedge clk);
  endtask

  task automatic check_result(input string tag, input int n, input bit loaded,
                              input int exp_valid, input logic exp_err, input int exp_cnt);
    int nw;
    int bad;
    nw  = loaded ? (n + ((n < 1024) ? 1 : 0)) : 0;
    bad = 0;
    chk({tag, "_nwrites"}, 64'(wa_q.size()), 64'(nw));
    for (int i = 0; i < wa_q.size() && i < nw; i++) begin
      if (wa_q[i] !== 10'(i)) bad++;
      if (wd_q[i] !== ((i < n) ? prog[i] : 33'd0)) bad++;
    end
    chk({tag, "_wr_content"}, 64'(bad), 64'd0);
    chk({tag, "_valid_pulses"}, 64'(vcnt), 64'(exp_valid));
    chk({tag, "_load_err"}, 64'(load_err), 64'(exp_err));
    chk({tag, "_ins_count"}, 64'(ins_count), 64'(exp_cnt));
    chk({tag, "_busy_idle"}, 64'(load_busy), 64'd0);
  endtask

  typedef struct {
    logic        vld;
    logic [7:0]  dat;
    logic        rdy;
    logic        wr;
    logic [9:0]  addr;
    logic [32:0] data;
    logic        iv;
    logic        busy;
    logic        err;
    logic [10:0] cnt;
  } vec_t;

  function automatic vec_t v(input logic vld, input logic [7:0] dat, input logic rdy,
                             input logic wr, input logic [9:0] addr, input logic [32:0] data,
                             input logic iv, input logic busy, input logic err,
                             input logic [10:0] cnt);
    vec_t r;
    r.vld = vld; r.dat = dat; r.rdy = rdy; r.wr = wr; r.addr = addr;
    r.data = data; r.iv = iv; r.busy = busy; r.err = err; r.cnt = cnt;
    return r;
  endfunction

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl [12];
    // Single ADD a=5 b=6 r=7; rows: drive inputs, expect current registered outputs.
    tbl[0]  = v(0, 8'h00, 0, 0, 10'd0, 33'h0,         0, 0, 0, 11'd0);
    tbl[1]  = v(1, 8'h01, 1, 0, 10'd0, 33'h0,         0, 0, 0, 11'd0);
    tbl[2]  = v(1, 8'h00, 1, 0, 10'd0, 33'h0,         0, 0, 0, 11'd0);
    tbl[3]  = v(1, 8'h39, 1, 0, 10'd0, 33'h0,         0, 1, 0, 11'd0);
    tbl[4]  = v(1, 8'hC0, 1, 0, 10'd0, 33'h0,         0, 1, 0, 11'd0);
    tbl[5]  = v(1, 8'h80, 1, 0, 10'd0, 33'h0,         0, 1, 0, 11'd0);
    tbl[6]  = v(1, 8'h02, 1, 0, 10'd0, 33'h0,         0, 1, 0, 11'd0);
    tbl[7]  = v(1, 8'h00, 1, 0, 10'd0, 33'h0,         0, 1, 0, 11'd0);
    tbl[8]  = v(0, 8'h00, 0, 1, 10'd0, 33'h0280C039,  0, 1, 0, 11'd0);
    tbl[9]  = v(0, 8'h00, 0, 1, 10'd1, 33'h0,         0, 1, 0, 11'd0);
    tbl[10] = v(0, 8'h00, 1, 0, 10'd1, 33'h0,         1, 0, 0, 11'd1);
    tbl[11] = v(0, 8'h00, 1, 0, 10'd1, 33'h0,         0, 0, 0, 11'd1);

    rstn = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_outputs", outs(), 64'd0);
    rstn = 1'b1;

`ifndef INS_LOADER_CHECKSUM_EN
    foreach (tbl[i]) begin
      chk($sformatf("add_row%0d", i), outs(),
          {5'b0, tbl[i].rdy, tbl[i].wr, tbl[i].addr, tbl[i].data,
           tbl[i].iv, tbl[i].busy, tbl[i].err, tbl[i].cnt});
      s_valid = tbl[i].vld;
      s_data  = tbl[i].dat;
      @(negedge clk);
    end
`else
    @(negedge clk);
    clear_mon();
    prog[0] = mk(OP_ADD, 10'd5, 10'd6, 10'd7);
    chk("add_word_const", 64'(prog[0]), 64'h0280C039);
    send_frame(1, 0, 0);
    check_result("add", 1, 1, 1, 1'b0, 1);
`endif

    // N = 0: just the terminator.
    clear_mon();
    send_frame(0, 0, 0);
    check_result("n0", 0, 1, 1, 1'b0, 0);

    // N = 3 with s_valid toggling every other cycle.
    clear_mon();
    prog[0] = mk(OP_SUB, 10'd1, 10'd2, 10'd3);
    prog[1] = mk(OP_DOT_ACC, 10'h3FF, 10'h155, 10'h2AA);
    prog[2] = mk(OP_MUL, 10'd0, 10'd512, 10'd1);
    send_frame(3, 1, 0);
    check_result("n3_gap", 3, 1, 1, 1'b0, 3);

    // Oversize count rejected, then a normal frame clears the error.
    clear_mon();
    send_frame(16'h0401, 0, 0);
    check_result("oversize", 0, 0, 0, 1'b1, 3);
    clear_mon();
    prog[0] = mk(OP_MUL, 10'h3FF, 10'd0, 10'd512);
    send_frame(1, 0, 0);
    check_result("after_oversize", 1, 1, 1, 1'b0, 1);

    // Full memory: no terminator.
    clear_mon();
    for (int i = 0; i < 1024; i++) prog[i] = mk(OP_PASS_B, 10'(i), 10'(1023 - i), 10'(i ^ 5));
    send_frame(1024, 0, 0);
    check_result("full", 1024, 1, 1, 1'b0, 1024);

    // Reset in the middle of the body.
    clear_mon();
    send_byte(8'h02, 0);
    send_byte(8'h00, 0);
    send_byte(8'hAA, 0);
    send_byte(8'h55, 0);
    send_byte(8'h33, 0);
    rstn = 1'b0;
    repeat (2) @(negedge clk);
    chk("midload_reset_outputs", outs(), 64'd0);
    rstn = 1'b1;
    @(negedge clk);
    chk("midload_no_activity", 64'(wa_q.size() + vcnt), 64'd0);
    clear_mon();
    prog[0] = mk(OP_DOT_CLR, 10'd9, 10'd8, 10'd7);
    send_frame(1, 0, 0);
    check_result("after_reset", 1, 1, 1, 1'b0, 1);

`ifdef INS_LOADER_CHECKSUM_EN
    // Bad checksum: writes stand, no pulse, count kept, error raised.
    clear_mon();
    prog[0] = mk(OP_ADD, 10'd1, 10'd1, 10'd1);
    prog[1] = mk(OP_DOT_SHIFT, 10'd2, 10'd2, 10'd2);
    send_frame(2, 0, 1);
    check_result("bad_csum", 2, 1, 0, 1'b1, 1);
`endif

    chk("valid_wr_overlap", 64'(overlap), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
